// File: rtl/led_mode_sequencer.sv
// Button-driven 2-bit LED mode register with per-button synchronizer, debouncer and press detect.
// Define LED_MODE_AUTO_CYCLE_EN to add the i_auto_en port and periodic automatic advance.
module led_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_PERIOD     = 50000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_next,
    input  logic       i_btn_prev,
`ifdef LED_MODE_AUTO_CYCLE_EN
    input  logic       i_auto_en,
`endif
    output logic [1:0] o_modeselector,
    output logic       o_mode_changed
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is the next button, bit 1 the prev button.
    logic [1:0]    w_btn;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_stable;
    logic [1:0]    r_stable_d;
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    w_press;
    logic          w_auto_ev;
    logic          w_next_ev;
    logic          w_prev_ev;
    logic [1:0]    r_mode;
    logic          r_changed;

    assign w_btn = {i_btn_prev, i_btn_next};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            r_cnt[0]   <= '0;
            r_cnt[1]   <= '0;
        end else begin
            r_sync1    <= w_btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_stable & ~r_stable_d;

`ifdef LED_MODE_AUTO_CYCLE_EN
    localparam int            AW        = $clog2(AUTO_PERIOD);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

    logic [AW-1:0] r_auto_cnt;

    assign w_auto_ev = i_auto_en && (r_auto_cnt == AUTO_LAST);

    // A manual press restarts the full auto period.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_auto_cnt <= '0;
        end else if (!i_auto_en) begin
            r_auto_cnt <= '0;
        end else if (w_press != 2'b00) begin
            r_auto_cnt <= '0;
        end else if (r_auto_cnt == AUTO_LAST) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end
`else
    assign w_auto_ev = 1'b0;
`endif

    assign w_next_ev = w_press[0] | w_auto_ev;
    assign w_prev_ev = w_press[1];

    // Opposing events in the same cycle cancel out.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode    <= 2'b00;
            r_changed <= 1'b0;
        end else if (w_next_ev && !w_prev_ev) begin
            r_mode    <= r_mode + 2'd1;
            r_changed <= 1'b1;
        end else if (w_prev_ev && !w_next_ev) begin
            r_mode    <= r_mode - 2'd1;
            r_changed <= 1'b1;
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign o_modeselector = r_mode;
    assign o_mode_changed = r_changed;

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
- Generates the 2-bit mode select consumed by the LED mode chooser.
- Takes raw, bouncing push-button inputs for "next mode" and "previous mode".
- Synchronizes and debounces each button, detects press events, and steps a wrapping mode register.
- Produces a one-cycle pulse on every mode change so pattern generators can restart cleanly.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive clock cycles a synchronized level must hold before it is accepted. Legal range 2..65535.
- AUTO_PERIOD, 50000000: clock cycles between automatic advances. Used only with LED_MODE_AUTO_CYCLE_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_next  input  1  raw asynchronous button, active high; a press advances the mode.
- btn_prev  input  1  raw asynchronous button, active high; a press steps the mode back.
- auto_en  input  1  enables automatic cycling. Only present with LED_MODE_AUTO_CYCLE_EN.
- modeselector  output  2  current mode: 00, 01, 10 or 11.
- mode_changed  output  1  one-cycle pulse in the cycle modeselector takes a new value.

Behaviour:
- Reset: one clock, synchronous, active high. While reset is high at a clock edge:
  - modeselector = 00, mode_changed = 0.
  - Synchronizer flops, debounced (stable) levels and debounce counters = 0.
  - Auto counter = 0.
  - Reset mid-debounce or mid-period discards all progress.
- Synchronizer: per button, a 2-flop chain (sync1 -> sync2). Only sync2 feeds later logic.
- Debounce, per button:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == stable, the counter clears to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, stable takes sync2 and the counter clears.
  - Any glitch back to the stable level restarts the count. Releases are debounced the same way.
- Press event: stable rises 0 -> 1 (registered previous-stable compare). One event per press, however long the button is held.
- Latency: raw input first sampled high at edge k and held steady gives:
  - stable = 1 after edge k+1+DEBOUNCE_CYCLES.
  - modeselector update and mode_changed = 1 after edge k+2+DEBOUNCE_CYCLES.
- Mode update, registered, evaluated every cycle:
  - next event only: modeselector + 1, with 11 -> 00 wrap.
  - prev event only: modeselector - 1, with 00 -> 11 wrap.
  - next and prev events in the same cycle: no change, mode_changed stays 0.
  - No event: hold.
- mode_changed: high for exactly the one cycle following the edge at which modeselector changes. It is never high two consecutive cycles unless two distinct changes occur in consecutive cycles.
- Button held high across reset release: stable restarts at 0, so the held button is accepted as one press after the debounce delay.
- No other state machine. The only state is the mode register, the debounce counters and the edge-detect flops.

Optional Feature:
- Macro: LED_MODE_AUTO_CYCLE_EN.
- Defined:
  - auto_en port exists.
  - An auto counter of width $clog2(AUTO_PERIOD) runs while auto_en = 1, and clears to 0 whenever auto_en = 0.
  - When the counter reaches AUTO_PERIOD-1, it wraps to 0 and generates an auto-next event.
  - The auto-next event is ORed with the next-button event, so next and auto in the same cycle give a single +1.
  - Any accepted button event (next, prev, or both) clears the auto counter, restarting the full period.
  - The auto-next event combines with prev using the same simultaneous rule: no change.
- Undefined: no auto_en port, no auto counter. The mode changes only on button presses.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
- Reset: hold reset 3 cycles, buttons low -> modeselector=00, mode_changed=0; outputs hold 00/0 for 20 more cycles.
- Clean press: btn_next high for 20 cycles, first sampled at edge k -> modeselector=01 and mode_changed=1 only after edge k+6. Release then 4 more clean presses -> 10, 11, 00, 01, with exactly one pulse each.
- Bounce: btn_next toggles high 3 cycles / low 1 cycle, 5 times, then stays high -> no change during bouncing. Exactly one step, 4 stable cycles (+2) after the last rising bounce.
- Prev wrap and simultaneity:
  - From 00, clean btn_prev press -> 11 with a pulse.
  - btn_next and btn_prev rising on the same edge, both held -> no change, no pulse.
- Reset mid-debounce: btn_next high, reset pulsed at 2 cycles into the debounce count, button kept high -> modeselector=00 through reset. A single step to 01 occurs 6 cycles after the reset-deasserted edge.
- With LED_MODE_AUTO_CYCLE_EN, auto_en=1 from reset -> modeselector advances every 8 cycles (01, 10, 11, 00) with a pulse each. A btn_prev press restarts the period. auto_en=0 freezes the mode.
